// File: rtl/sssp_edge_expander.sv
// SSSP edge expander: reads a vertex's offset pair, fetches its neighbour list in
// bursts of up to MAX_BURST beats and streams one child task per edge.
module sssp_edge_expander #(
    parameter int TS_W      = 32,
    parameter int LOC_W     = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int TILE_ID   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cfg_offset_base,
    input  logic [ADDR_W-1:0] cfg_neighbor_base,
    input  logic              cfg_unit_weight,
    input  logic              task_in_valid,
    output logic              task_in_ready,
    input  logic [TS_W-1:0]   in_ts,
    input  logic [LOC_W-1:0]  in_locale,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    input  logic              rvalid,
    output logic              rready,
    input  logic [63:0]       rdata,
    input  logic              rlast,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TS_W-1:0]   out_ts,
    output logic [LOC_W-1:0]  out_locale,
    output logic              out_last,
    output logic              done_valid,
    output logic              busy,
    output logic [31:0]       edge_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OFF_REQ,
        S_OFF_WAIT,
        S_NBR_REQ,
        S_NBR_STREAM,
        S_DONE
    } state_t;

    localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);

    // The tile index has no hardware role; it only tags instances when debugging.
    if (TILE_ID < 0) begin : g_invalid_tile_id
    end

    state_t            state_reg;
    logic [TS_W-1:0]   ts_reg;
    logic [31:0]       cur_reg;
    logic [31:0]       remaining_reg;
    logic              arvalid_reg;
    logic [ADDR_W-1:0] araddr_reg;
    logic [7:0]        arlen_reg;
    logic              done_valid_reg;
    logic [31:0]       edge_count_reg;

    function automatic logic [7:0] burst_arlen(input logic [31:0] rem);
        logic [31:0] len;
        len = (rem < MAX_BURST_W) ? rem : MAX_BURST_W;
        return 8'(len - 32'd1);
    endfunction

    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [31:0]       idx);
        return base + (ADDR_W'(idx) << 3);
    endfunction

    logic              in_stream;
    logic              out_fire;
    logic [31:0]       off_start;
    logic [31:0]       off_end;
    logic [31:0]       cur_len;
    logic [TS_W-1:0]   weight;
    logic [TS_W:0]     ts_sum;

    assign in_stream = (state_reg == S_NBR_STREAM);
    assign off_start = rdata[31:0];
    assign off_end   = rdata[63:32];
    assign cur_len   = 32'(arlen_reg) + 32'd1;

    // Child path is a zero-latency pass-through of the response beat.
    assign weight = cfg_unit_weight ? {{(TS_W-1){1'b0}}, 1'b1} : TS_W'(rdata[63:32]);
    assign ts_sum = {1'b0, ts_reg} + {1'b0, weight};

    assign out_valid  = in_stream & rvalid;
    assign out_fire   = out_valid & out_ready;
    assign out_ts     = ts_sum[TS_W] ? {TS_W{1'b1}} : ts_sum[TS_W-1:0];
    assign out_locale = rdata[LOC_W-1:0];
    assign out_last   = in_stream & rlast & (remaining_reg == 32'd0);
    assign rready     = (state_reg == S_OFF_WAIT) | (in_stream & out_ready);

    assign task_in_ready = (state_reg == S_IDLE);
    assign busy          = (state_reg != S_IDLE);
    assign arvalid       = arvalid_reg;
    assign araddr        = araddr_reg;
    assign arlen         = arlen_reg;
    assign arsize        = 3'd3;
    assign done_valid    = done_valid_reg;
    assign edge_count    = edge_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            ts_reg         <= '0;
            cur_reg        <= '0;
            remaining_reg  <= '0;
            arvalid_reg    <= 1'b0;
            araddr_reg     <= '0;
            arlen_reg      <= '0;
            done_valid_reg <= 1'b0;
            edge_count_reg <= '0;
        end else begin
            done_valid_reg <= 1'b0;
            if (out_fire) begin
                edge_count_reg <= edge_count_reg + 32'd1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (task_in_valid) begin
                        ts_reg      <= in_ts;
                        arvalid_reg <= 1'b1;
                        araddr_reg  <= beat_addr(cfg_offset_base, 32'(in_locale));
                        arlen_reg   <= 8'd0;
                        state_reg   <= S_OFF_REQ;
                    end
                end
                S_OFF_REQ: begin
                    if (arready) begin
                        arvalid_reg <= 1'b0;
                        state_reg   <= S_OFF_WAIT;
                    end
                end
                S_OFF_WAIT: begin
                    if (rvalid) begin
                        if (off_end <= off_start) begin
                            done_valid_reg <= 1'b1;
                            state_reg      <= S_DONE;
                        end else begin
                            cur_reg       <= off_start;
                            remaining_reg <= off_end - off_start;
                            arvalid_reg   <= 1'b1;
                            araddr_reg    <= beat_addr(cfg_neighbor_base, off_start);
                            arlen_reg     <= burst_arlen(off_end - off_start);
                            state_reg     <= S_NBR_REQ;
                        end
                    end
                end
                S_NBR_REQ: begin
                    // Cursor advances at request time so out_last can see the final burst.
                    if (arready) begin
                        arvalid_reg   <= 1'b0;
                        cur_reg       <= cur_reg + cur_len;
                        remaining_reg <= remaining_reg - cur_len;
                        state_reg     <= S_NBR_STREAM;
                    end
                end
                S_NBR_STREAM: begin
                    if (out_fire && rlast) begin
                        if (remaining_reg == 32'd0) begin
                            done_valid_reg <= 1'b1;
                            state_reg      <= S_DONE;
                        end else begin
                            arvalid_reg <= 1'b1;
                            araddr_reg  <= beat_addr(cfg_neighbor_base, cur_reg);
                            arlen_reg   <= burst_arlen(remaining_reg);
                            state_reg   <= S_NBR_REQ;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sssp_edge_expander.sv
// Scoreboard bench for sssp_edge_expander: a memory-backed read slave answers the
// DUT, stimulus queues expected requests/children, monitors pop and compare.
module tb_sssp_edge_expander;

    localparam int TS_W      = 32;
    localparam int LOC_W     = 32;
    localparam int ADDR_W    = 32;
    localparam int MAX_BURST = 4;
    localparam logic [31:0] OFF_BASE = 32'h0000_1000;
    localparam logic [31:0] NBR_BASE = 32'h0000_8000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] cfg_offset_base = OFF_BASE;
    logic [ADDR_W-1:0] cfg_neighbor_base = NBR_BASE;
    logic              cfg_unit_weight = 1'b0;
    logic              task_in_valid = 1'b0;
    logic              task_in_ready;
    logic [TS_W-1:0]   in_ts = '0;
    logic [LOC_W-1:0]  in_locale = '0;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic              rvalid;
    logic              rready;
    logic [63:0]       rdata;
    logic              rlast;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [TS_W-1:0]   out_ts;
    logic [LOC_W-1:0]  out_locale;
    logic              out_last;
    logic              done_valid;
    logic              busy;
    logic [31:0]       edge_count;

    always #5 clk = ~clk;

    sssp_edge_expander #(
        .TS_W(TS_W), .LOC_W(LOC_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .TILE_ID(0)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_offset_base(cfg_offset_base), .cfg_neighbor_base(cfg_neighbor_base),
        .cfg_unit_weight(cfg_unit_weight),
        .task_in_valid(task_in_valid), .task_in_ready(task_in_ready),
        .in_ts(in_ts), .in_locale(in_locale),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
        .out_locale(out_locale), .out_last(out_last),
        .done_valid(done_valid), .busy(busy), .edge_count(edge_count)
    );

    typedef struct { logic [31:0] loc; logic [31:0] ts; logic last; } child_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;

    child_t exp_q[$];
    ar_t    ar_q[$];
    logic [63:0] mem [logic [31:0]];
    int n_vec = 0;
    int n_err = 0;
    int done_seen = 0;
    int done_exp = 0;
    int ar_delay = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic put_off(input logic [31:0] loc, input logic [31:0] s, input logic [31:0] e);
        mem[OFF_BASE + loc * 8] = {e, s};
    endtask

    task automatic put_edge(input logic [31:0] idx, input logic [31:0] loc, input logic [31:0] w);
        mem[NBR_BASE + idx * 8] = {w, loc};
    endtask

    task automatic exp_ar(input logic [31:0] a, input logic [7:0] l);
        ar_t r;
        r.addr = a; r.len = l;
        ar_q.push_back(r);
    endtask

    task automatic exp_child(input logic [31:0] loc, input logic [31:0] ts, input logic last);
        child_t c;
        c.loc = loc; c.ts = ts; c.last = last;
        exp_q.push_back(c);
    endtask

    // Monitor: one line per observed transaction, compared against the queues.
    always @(negedge clk) begin
        child_t c;
        ar_t    r;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_child: got locale 0x%0h, required none", out_locale);
                end else begin
                    c = exp_q.pop_front();
                    $display("child locale=%0d ts=0x%0h last=%0b", out_locale, out_ts, out_last);
                    check("child_locale", 64'(out_locale), 64'(c.loc));
                    check("child_ts", 64'(out_ts), 64'(c.ts));
                    check("child_last", 64'(out_last), 64'(c.last));
                end
            end
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_ar: got araddr 0x%0h, required none", araddr);
                end else begin
                    r = ar_q.pop_front();
                    $display("read araddr=0x%0h arlen=%0d", araddr, arlen);
                    check("araddr", 64'(araddr), 64'(r.addr));
                    check("arlen", 64'(arlen), 64'(r.len));
                    check("arsize", 64'(arsize), 64'd3);
                end
            end
            if (done_valid) begin
                done_seen++;
                $display("done pulse edge_count=%0d", edge_count);
            end
        end
    end

    // Read slave: one request at a time, beats from mem, aborts on reset.
    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        logic        abort;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
        forever begin
            @(negedge clk);
            if (arvalid && !rst) begin
                a = araddr; l = arlen;
                for (int d = 0; d < ar_delay; d++) begin
                    @(negedge clk);
                    check("araddr_stable", 64'(araddr), 64'(a));
                    check("arlen_stable", 64'(arlen), 64'(l));
                end
                @(posedge clk); #1 arready = 1'b1;
                @(posedge clk); #1 arready = 1'b0;
                abort = 1'b0;
                for (int b = 0; b <= int'(l) && !abort; b++) begin
                    rvalid = 1'b1;
                    rdata  = mem.exists(a + 32'(8 * b)) ? mem[a + 32'(8 * b)] : 64'd0;
                    rlast  = (b == int'(l));
                    forever begin
                        @(negedge clk);
                        if (rst) begin abort = 1'b1; break; end
                        if (rready) break;
                    end
                    if (!abort) begin @(posedge clk); #1; end
                end
                rvalid = 1'b0; rlast = 1'b0;
            end
        end
    end

    task automatic offer_task(input logic [31:0] loc, input logic [31:0] ts);
        int t;
        @(posedge clk); #1;
        task_in_valid = 1'b1; in_ts = ts; in_locale = loc;
        t = 0;
        while (!task_in_ready && t < 50) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        task_in_valid = 1'b0;
    endtask

    task automatic run_vertex(input logic [31:0] loc, input logic [31:0] ts);
        int t;
        int d0;
        d0 = done_seen;
        done_exp++;
        offer_task(loc, ts);
        t = 0;
        while (done_seen == d0 && t < 500) begin @(posedge clk); #1; t++; end
        check("vertex_done", 64'(done_seen), 64'(d0 + 1));
        @(negedge clk);
        check("done_one_cycle", 64'(done_valid), 64'd0);
        check("children_left", 64'(exp_q.size()), 64'd0);
        check("reads_left", 64'(ar_q.size()), 64'd0);
    endtask

    task automatic setup_vertex1;
        put_off(5, 10, 13);
        put_edge(10, 7, 4); put_edge(11, 8, 1); put_edge(12, 9, 0);
        exp_ar(OFF_BASE + 40, 0);
        exp_ar(NBR_BASE + 80, 2);
        exp_child(7, 104, 0); exp_child(8, 101, 0); exp_child(9, 100, 1);
    endtask

    initial begin
        int t;
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        check("rst_task_in_ready", 64'(task_in_ready), 64'd1);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_edge_count", 64'(edge_count), 64'd0);
        rst = 1'b0;

        // Single short burst with mixed weights.
        setup_vertex1();
        run_vertex(5, 100);
        check("edge_count_v1", 64'(edge_count), 64'd3);

        // Ten edges split 4/4/2, delayed arready, mid-stream back-pressure.
        put_off(6, 0, 10);
        for (int i = 0; i < 10; i++) begin
            put_edge(i, 100 + i, i);
            exp_child(100 + i, 1000 + i, i == 9);
        end
        exp_ar(OFF_BASE + 48, 0);
        exp_ar(NBR_BASE + 0, 3); exp_ar(NBR_BASE + 32, 3); exp_ar(NBR_BASE + 64, 1);
        ar_delay = 3;
        fork
            run_vertex(6, 1000);
            begin
                t = 0;
                while (exp_q.size() > 8 && t < 300) begin @(posedge clk); #1; t++; end
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("rready_stall", 64'(rready), 64'd0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        ar_delay = 0;
        check("edge_count_v2", 64'(edge_count), 64'd13);

        // Empty neighbour list and reversed offsets: no neighbour reads.
        put_off(7, 20, 20);
        exp_ar(OFF_BASE + 56, 0);
        run_vertex(7, 55);
        put_off(10, 50, 40);
        exp_ar(OFF_BASE + 80, 0);
        run_vertex(10, 55);
        check("edge_count_empty", 64'(edge_count), 64'd13);

        // Unit-weight mode ignores the stored weight.
        cfg_unit_weight = 1'b1;
        put_off(8, 30, 31);
        put_edge(30, 42, 500);
        exp_ar(OFF_BASE + 64, 0); exp_ar(NBR_BASE + 240, 0);
        exp_child(42, 8, 1);
        run_vertex(8, 7);
        cfg_unit_weight = 1'b0;

        // Timestamp saturation on carry out.
        put_off(9, 31, 32);
        put_edge(31, 43, 32'h20);
        exp_ar(OFF_BASE + 72, 0); exp_ar(NBR_BASE + 248, 0);
        exp_child(43, 32'hFFFF_FFFF, 1);
        run_vertex(9, 32'hFFFF_FFF0);
        check("edge_count_v5", 64'(edge_count), 64'd15);

        // Reset while streaming: vertex dropped silently.
        put_off(11, 0, 3);
        exp_ar(OFF_BASE + 88, 0); exp_ar(NBR_BASE + 0, 2);
        out_ready = 1'b0;
        offer_task(11, 9);
        t = 0;
        while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
        check("stream_reached", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_task_in_ready", 64'(task_in_ready), 64'd1);
        check("mid_rst_arvalid", 64'(arvalid), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_last", 64'(out_last), 64'd0);
        check("mid_rst_done", 64'(done_valid), 64'd0);
        check("mid_rst_edge_count", 64'(edge_count), 64'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        setup_vertex1();
        run_vertex(5, 100);
        check("edge_count_after_rst", 64'(edge_count), 64'd3);

        repeat (5) @(posedge clk);
        check("done_total", 64'(done_seen), 64'(done_exp));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
